// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte-stream requesters; one message per grant.
// Latency: request -> grant +1, tx_start/req_ready +2; requesters wait on req_ready, uart_tx gates via tx_done_tick.
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int HOLD_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 abort,
  output logic                 tx_start,
  output logic [7:0]           tx_din,
  input  logic                 tx_done_tick
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam logic [CW:0] HOLD_LIM = (CW+1)'(HOLD_TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, WAIT_BYTE} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   owner_next;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic            last_f;
  logic [CW-1:0]   hold_cnt;
  logic            hold_expired;
  logic [7:0]      data_arr [N_REQ];

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      data_arr[k] = req_data[8*k +: 8];
    end
  end

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin : pick
    logic [IW:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (req_valid[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  assign owner_next = (owner == IW'(N_REQ-1)) ? '0 : owner + IW'(1);

  // hold_cnt holds the number of cycles elapsed since the tick that ended the previous byte.
  assign hold_expired = (HOLD_TIMEOUT != 0) && (({1'b0, hold_cnt} + (CW+1)'(1)) >= HOLD_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      last_f    <= 1'b0;
      hold_cnt  <= '0;
      req_ready <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      abort     <= 1'b0;
      tx_start  <= 1'b0;
      tx_din    <= 8'h00;
    end else begin
      tx_start  <= 1'b0;
      req_ready <= '0;
      abort     <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner <= pick_idx;
            grant <= N_REQ'(1) << pick_idx;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          tx_start  <= 1'b1;
          tx_din    <= data_arr[owner];
          req_ready <= N_REQ'(1) << owner;
          last_f    <= req_last[owner];
          state     <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done_tick) begin
            if (last_f) begin
              grant  <= '0;
              busy   <= 1'b0;
              rr_ptr <= owner_next;
              state  <= IDLE;
            end else begin
              hold_cnt <= CW'(1);
              state    <= WAIT_BYTE;
            end
          end
        end
        WAIT_BYTE: begin
          if (req_valid[owner]) begin
            hold_cnt <= '0;
            state    <= LOAD;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
            if (hold_expired) begin
              abort  <= 1'b1;
              grant  <= '0;
              busy   <= 1'b0;
              rr_ptr <= owner_next;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter against a message-level reference model.
module tb_uart_tx_arbiter;
  localparam int N    = 2;
  localparam int HOLD = 16;
  localparam int P_FREE = 0, P_SEND = 1, P_FLIGHT = 2, P_WAIT = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           abort;
  logic           tx_start;
  logic [7:0]     tx_din;
  logic           tx_done_tick;

  uart_tx_arbiter #(.N_REQ(N), .HOLD_TIMEOUT(HOLD)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .busy(busy), .abort(abort),
    .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         delay;
  } byte_t;

  byte_t rq [N][$];
  int    wait_cnt [N];
  bit    started [N];

  int n_vec = 0, n_err = 0, cyc = 0;

  // reference model of the link owner and expected outputs for the next cycle
  int           m_owner, m_rr, m_phase, m_tick_cyc;
  logic         m_last;
  logic [N-1:0] e_grant, e_ready;
  logic         e_start, e_abort;
  logic [7:0]   e_din;

  int done_at, dly_min, dly_max;
  bit spur_en, force_tick;

  logic [7:0]   tx_log [$];
  int           start_cyc [$];
  logic [N-1:0] ready_log [$];
  logic [N-1:0] grant_log [$];
  int           grant_cyc [$];
  int           fall_cyc [$];
  int           abort_cyc [$];
  int           tick_cyc [$];
  int           first_valid_cyc;
  logic [N-1:0] prev_grant;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_phase = P_FREE; m_tick_cyc = 0; m_last = 1'b0;
    e_grant = '0; e_ready = '0; e_start = 1'b0; e_abort = 1'b0; e_din = 8'h00;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      rq[i].delete(); wait_cnt[i] = 0; started[i] = 1'b0;
    end
    done_at = -1; force_tick = 1'b0;
    tx_log.delete(); start_cyc.delete(); ready_log.delete(); grant_log.delete();
    grant_cyc.delete(); fall_cyc.delete(); abort_cyc.delete(); tick_cyc.delete();
    first_valid_cyc = -1; prev_grant = '0;
    model_reset();
  endtask

  task automatic push(int i, logic [7:0] d, logic l, int dl);
    byte_t b;
    b.data = d; b.last = l; b.delay = dl;
    if (rq[i].size() == 0) wait_cnt[i] = dl;
    rq[i].push_back(b);
  endtask

  task automatic pop_head(int i);
    started[i] = !rq[i][0].last;
    void'(rq[i].pop_front());
    if (rq[i].size() > 0) wait_cnt[i] = rq[i][0].delay;
  endtask

  // Message-level rules: round-robin pick from free, one byte per uart completion, timeout after a tick.
  task automatic predict(logic [N-1:0] v, logic [8*N-1:0] dv, logic [N-1:0] lv, logic tk);
    e_start = 1'b0; e_ready = '0; e_abort = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    case (m_phase)
      P_FREE: if (v != 0) begin
        for (int k = N-1; k >= 0; k--) if (v[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
        m_phase = P_SEND;
      end
      P_SEND: begin
        e_start = 1'b1;
        e_ready[m_owner] = 1'b1;
        e_din = dv[8*m_owner +: 8];
        m_last = lv[m_owner];
        m_phase = P_FLIGHT;
      end
      P_FLIGHT: if (tk) begin
        m_tick_cyc = cyc;
        if (m_last) begin
          m_rr = (m_owner + 1) % N; m_owner = -1; m_phase = P_FREE;
        end else m_phase = P_WAIT;
      end
      default: begin
        if (v[m_owner]) m_phase = P_SEND;
        else if (cyc + 1 - m_tick_cyc == HOLD) begin
          e_abort = 1'b1; m_rr = (m_owner + 1) % N; m_owner = -1; m_phase = P_FREE;
        end
      end
    endcase
    e_grant = (m_owner < 0) ? '0 : N'(1) << m_owner;
  endtask

  task automatic step();
    logic [N-1:0]   v;
    logic [8*N-1:0] dv;
    logic [N-1:0]   lv;
    logic           tk;
    @(posedge clk); #1; cyc++;
    chk("grant", grant, e_grant);
    chk("busy", busy, |e_grant);
    chk("req_ready", req_ready, e_ready);
    chk("tx_start", tx_start, e_start);
    chk("tx_din", tx_din, e_din);
    chk("abort", abort, e_abort);
    if (tx_start) begin
      tx_log.push_back(tx_din); start_cyc.push_back(cyc); ready_log.push_back(req_ready);
      chk("start_while_uart_busy", done_at < 0, 1);
      done_at = cyc + $urandom_range(dly_max, dly_min);
    end
    if (grant != 0 && prev_grant == 0) begin grant_log.push_back(grant); grant_cyc.push_back(cyc); end
    if (grant == 0 && prev_grant != 0) fall_cyc.push_back(cyc);
    prev_grant = grant;
    if (abort) abort_cyc.push_back(cyc);
    for (int i = 0; i < N; i++) if (req_ready[i] && rq[i].size() > 0) pop_head(i);
    if (abort) begin
      for (int i = 0; i < N; i++) begin
        if (started[i]) begin
          bit fin = 1'b0;
          while (!fin && rq[i].size() > 0) begin fin = rq[i][0].last; pop_head(i); end
        end
      end
    end
    v = '0; lv = '0; dv = (8*N)'($urandom);
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        dv[8*i +: 8] = rq[i][0].data;
        lv[i] = rq[i][0].last;
        v[i] = (wait_cnt[i] == 0);
        if (wait_cnt[i] > 0) wait_cnt[i]--;
      end
    end
    tk = 1'b0;
    if (done_at == cyc) begin
      tk = 1'b1; done_at = -1; tick_cyc.push_back(cyc);
    end else if (done_at < 0 && m_owner < 0 && (force_tick || (spur_en && $urandom_range(7, 0) == 0)))
      tk = 1'b1;
    if (v != 0 && first_valid_cyc < 0) first_valid_cyc = cyc;
    req_valid = v; req_data = dv; req_last = lv; tx_done_tick = tk;
    predict(v, dv, lv, tk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_all();
    req_valid = '0; req_data = '0; req_last = '0; tx_done_tick = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic drain(int budget);
    int n = 0;
    bit pend;
    pend = 1'b1;
    while (pend && n < budget) begin
      step(); n++;
      pend = (m_phase != P_FREE) || (done_at >= 0);
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) pend = 1'b1;
    end
    chk("drain_timeout", pend, 0);
    step(); step();
  endtask

  initial begin
    logic [7:0]   at_ok [6];
    logic [N-1:0] alt [4];
    int n;
    at_ok = '{8'h41, 8'h54, 8'h0D, 8'h0A, 8'h4F, 8'h4B};
    alt   = '{2'b01, 2'b10, 2'b01, 2'b10};
    dly_min = 4; dly_max = 4; spur_en = 1'b0;

    // reset values
    do_reset();
    reset = 1'b1; step();
    chk("reset_grant", grant, 0); chk("reset_busy", busy, 0); chk("reset_tx_din", tx_din, 0);
    chk("reset_tx_start", tx_start, 0); chk("reset_req_ready", req_ready, 0); chk("reset_abort", abort, 0);
    reset = 1'b0;

    // single byte, latency
    do_reset();
    push(0, 8'h41, 1'b1, 0);
    drain(200);
    chk("single_grant_lat", grant_cyc[0] - first_valid_cyc, 1);
    chk("single_start_lat", start_cyc[0] - first_valid_cyc, 2);
    chk("single_din", tx_log[0], 8'h41);
    chk("single_ready", ready_log[0], 2'b01);
    chk("single_grant_who", grant_log[0], 2'b01);
    chk("single_release", fall_cyc[0] - tick_cyc[0], 1);
    chk("single_busy_after", busy, 0);

    // two simultaneous messages stay atomic
    do_reset();
    push(0, 8'h41, 0, 0); push(0, 8'h54, 0, 0); push(0, 8'h0D, 0, 0); push(0, 8'h0A, 1, 0);
    push(1, 8'h4F, 0, 0); push(1, 8'h4B, 1, 0);
    drain(400);
    chk("atok_count", tx_log.size(), 6);
    for (int k = 0; k < 6 && k < tx_log.size(); k++) chk($sformatf("atok_byte%0d", k), tx_log[k], at_ok[k]);

    // fairness under continuous 1-byte traffic
    do_reset();
    for (int k = 0; k < 4; k++) begin push(0, 8'(8'h10 + k), 1, 0); push(1, 8'(8'h20 + k), 1, 0); end
    drain(600);
    chk("alt_count", grant_log.size(), 8);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) chk($sformatf("alt_grant%0d", k), grant_log[k], alt[k]);

    // stalled message times out, pending requester served next
    do_reset();
    push(1, 8'h55, 0, 0); push(1, 8'h56, 1, 40); push(0, 8'h30, 1, 3);
    drain(400);
    chk("to_first_grant", grant_log[0], 2'b10);
    chk("to_abort_count", abort_cyc.size(), 1);
    chk("to_abort_time", abort_cyc[0] - tick_cyc[0], HOLD);
    chk("to_next_grant", grant_log[1], 2'b01);
    chk("to_next_grant_time", grant_cyc[1] - abort_cyc[0], 1);
    chk("to_bytes", {tx_log[0], tx_log[1]}, 16'h5530);

    // reset during a message
    do_reset();
    push(0, 8'h61, 0, 0); push(0, 8'h62, 0, 0); push(0, 8'h63, 1, 0);
    n = 0;
    while (tx_log.size() == 0 && n < 50) begin step(); n++; end
    chk("mid_reset_reached", tx_log.size(), 1);
    step();
    reset = 1'b1; #1;
    chk("mid_reset_grant", grant, 0); chk("mid_reset_busy", busy, 0); chk("mid_reset_din", tx_din, 0);
    chk("mid_reset_ready", req_ready, 0); chk("mid_reset_start", tx_start, 0); chk("mid_reset_abort", abort, 0);
    clear_all();
    req_valid = '0; tx_done_tick = 1'b0;
    step(); step();
    reset = 1'b0;
    push(1, 8'h31, 1, 0);
    drain(200);
    chk("post_reset_grant", grant_log[0], 2'b10);
    chk("post_reset_byte", tx_log[0], 8'h31);

    // stray tick while idle
    do_reset();
    force_tick = 1'b1; step(); force_tick = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("stray_tick_starts", tx_log.size(), 0);
    chk("stray_tick_grants", grant_log.size(), 0);

    // random traffic
    dly_min = 2; dly_max = 9; spur_en = 1'b1;
    do_reset();
    for (int i = 0; i < N; i++) begin
      for (int m = 0; m < 25; m++) begin
        int len = $urandom_range(4, 1);
        for (int b = 0; b < len; b++) begin
          int dl = (b == 0) ? $urandom_range(3, 0)
                            : (($urandom_range(99, 0) < 15) ? 40 : $urandom_range(3, 0));
          push(i, 8'($urandom), (b == len - 1), dl);
        end
      end
    end
    drain(20000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
